// File: rtl/brick_pixel_renderer.sv
// Pipelined pixel colour generator for the brick-breaker display path.
// Resolves win/lose screens, paddle, bricks (with a per-brick shrink-out
// animation stepped by frame_tick) and the ball, two clocks after the pixel.
module brick_pixel_renderer #(
  parameter int NUM_BRICKS  = 9,
  parameter int COORD_W     = 10,
  parameter int COLOR_W     = 8,
  parameter int SHRINK_STEP = 1
) (
  input  logic                            Clk,
  input  logic                            Reset_n,
  input  logic                            frame_tick,
  input  logic                            pix_valid,
  input  logic [COORD_W-1:0]              DrawX,
  input  logic [COORD_W-1:0]              DrawY,
  input  logic [COORD_W-1:0]              BallX,
  input  logic [COORD_W-1:0]              BallY,
  input  logic [COORD_W-1:0]              Ball_size,
  input  logic [NUM_BRICKS-1:0]           brick_exists,
  input  logic [NUM_BRICKS*COORD_W-1:0]   brick_x_vals,
  input  logic [NUM_BRICKS*COORD_W-1:0]   brick_y_vals,
  input  logic [COORD_W-1:0]              brick_width,
  input  logic [COORD_W-1:0]              brick_height,
  input  logic [COORD_W-1:0]              paddle_x,
  input  logic [COORD_W-1:0]              paddle_y,
  input  logic [COORD_W-1:0]              paddle_width,
  input  logic [COORD_W-1:0]              paddle_height,
  input  logic                            did_win_game,
  input  logic                            did_lose_game,
  input  logic                            text_pix_on,
  output logic [COLOR_W-1:0]              Red,
  output logic [COLOR_W-1:0]              Green,
  output logic [COLOR_W-1:0]              Blue,
  output logic                            rgb_valid
);

  localparam int CW1 = COORD_W + 1;
  localparam int CW2 = COORD_W + 2;
  localparam int SQW = 2 * COORD_W + 2;

  typedef enum logic [1:0] {GONE = 2'd0, ALIVE = 2'd1, SHRINKING = 2'd2} brick_state_t;

  brick_state_t       state   [NUM_BRICKS];
  brick_state_t       state_n [NUM_BRICKS];
  logic [COORD_W-1:0] inset   [NUM_BRICKS];
  logic [COORD_W-1:0] inset_n [NUM_BRICKS];
  logic [COORD_W-1:0] grown   [NUM_BRICKS];
  logic [COORD_W-1:0] min_side;

  // Inset grows by SHRINK_STEP and sticks at all-ones instead of wrapping.
  function automatic logic [COORD_W-1:0] sat_step(input logic [COORD_W-1:0] a);
    logic [CW1-1:0] s;
    s = {1'b0, a} + CW1'(SHRINK_STEP);
    return s[COORD_W] ? {COORD_W{1'b1}} : s[COORD_W-1:0];
  endfunction

  // Half-open lo <= d < lo+size, sum widened so edges near full scale don't wrap.
  function automatic logic span_hit(input logic [COORD_W-1:0] d, lo, size);
    return (d >= lo) && ({1'b0, d} < ({1'b0, lo} + {1'b0, size}));
  endfunction

  function automatic logic span_edge(input logic [COORD_W-1:0] d, lo, size);
    return (d == lo) || (({1'b0, d} + CW1'(1)) == ({1'b0, lo} + {1'b0, size}));
  endfunction

  // Shrunken span [lo+ins, lo+size-ins), rearranged to avoid subtraction.
  function automatic logic shrink_hit(input logic [COORD_W-1:0] d, lo, size, ins);
    return ({2'b0, d} >= ({2'b0, lo} + {2'b0, ins})) &&
           (({2'b0, d} + {2'b0, ins}) < ({2'b0, lo} + {2'b0, size}));
  endfunction

  // Scale an 8-bit channel constant to COLOR_W bits.
  function automatic logic [COLOR_W-1:0] chan(input logic [7:0] c8);
    logic [COLOR_W+7:0] t;
    t = {c8, {COLOR_W{1'b0}}};
    return t[COLOR_W+7:8];
  endfunction

  assign min_side = (brick_width < brick_height) ? brick_width : brick_height;

  // Brick state registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_BRICKS; i++) begin
        state[i] <= GONE;
        inset[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BRICKS; i++) begin
        state[i] <= state_n[i];
        inset[i] <= inset_n[i];
      end
    end
  end

  // Brick next-state: exists flag dominates, dying bricks shrink on frame_tick.
  always_comb begin
    for (int i = 0; i < NUM_BRICKS; i++) begin
      state_n[i] = state[i];
      inset_n[i] = inset[i];
      grown[i]   = frame_tick ? sat_step(inset[i]) : inset[i];
      case (state[i])
        GONE: begin
          if (brick_exists[i]) begin
            state_n[i] = ALIVE;
            inset_n[i] = '0;
          end
        end
        ALIVE: begin
          if (!brick_exists[i]) begin
            state_n[i] = SHRINKING;
            inset_n[i] = '0;
          end
        end
        SHRINKING: begin
          if (brick_exists[i]) begin
            state_n[i] = ALIVE;
            inset_n[i] = '0;
          end else if ({grown[i], 1'b0} >= {1'b0, min_side}) begin
            state_n[i] = GONE;
            inset_n[i] = '0;
          end else begin
            inset_n[i] = grown[i];
          end
        end
        default: begin
          state_n[i] = GONE;
          inset_n[i] = '0;
        end
      endcase
    end
  end

  logic hit_alive, hit_edge, hit_shrink, hit_paddle, hit_ball;
  logic signed [CW1-1:0] dx, dy;
  logic signed [SQW-1:0] dx2, dy2;
  logic [SQW-1:0]        dist2, r2;

  // Combinational hit tests for the current pixel.
  always_comb begin
    hit_alive  = 1'b0;
    hit_edge   = 1'b0;
    hit_shrink = 1'b0;
    for (int i = 0; i < NUM_BRICKS; i++) begin
      if (state[i] == ALIVE &&
          span_hit(DrawX, brick_x_vals[COORD_W*i +: COORD_W], brick_width) &&
          span_hit(DrawY, brick_y_vals[COORD_W*i +: COORD_W], brick_height)) begin
        hit_alive = 1'b1;
        if (span_edge(DrawX, brick_x_vals[COORD_W*i +: COORD_W], brick_width) ||
            span_edge(DrawY, brick_y_vals[COORD_W*i +: COORD_W], brick_height))
          hit_edge = 1'b1;
      end
      if (state[i] == SHRINKING &&
          shrink_hit(DrawX, brick_x_vals[COORD_W*i +: COORD_W], brick_width, inset[i]) &&
          shrink_hit(DrawY, brick_y_vals[COORD_W*i +: COORD_W], brick_height, inset[i]))
        hit_shrink = 1'b1;
    end
    hit_paddle = span_hit(DrawX, paddle_x, paddle_width) &&
                 span_hit(DrawY, paddle_y, paddle_height);
    dx    = $signed({1'b0, DrawX}) - $signed({1'b0, BallX});
    dy    = $signed({1'b0, DrawY}) - $signed({1'b0, BallY});
    dx2   = SQW'(dx) * SQW'(dx);
    dy2   = SQW'(dy) * SQW'(dy);
    dist2 = $unsigned(dx2) + $unsigned(dy2);
    r2    = SQW'(Ball_size) * SQW'(Ball_size);
    hit_ball = (dist2 <= r2);
  end

  logic vld_p1, alive_p1, edge_p1, shrink_p1, paddle_p1, ball_p1, win_p1, lose_p1, text_p1;

  // Stage 1: register hit flags and overlays, all gated by pix_valid.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_p1    <= 1'b0;
      alive_p1  <= 1'b0;
      edge_p1   <= 1'b0;
      shrink_p1 <= 1'b0;
      paddle_p1 <= 1'b0;
      ball_p1   <= 1'b0;
      win_p1    <= 1'b0;
      lose_p1   <= 1'b0;
      text_p1   <= 1'b0;
    end else begin
      vld_p1    <= pix_valid;
      alive_p1  <= pix_valid & hit_alive;
      edge_p1   <= pix_valid & hit_edge;
      shrink_p1 <= pix_valid & hit_shrink;
      paddle_p1 <= pix_valid & hit_paddle;
      ball_p1   <= pix_valid & hit_ball;
      win_p1    <= pix_valid & did_win_game;
      lose_p1   <= pix_valid & did_lose_game;
      text_p1   <= pix_valid & text_pix_on;
    end
  end

  logic [23:0] rgb_sel;

  // Colour priority: win, lose, paddle, alive brick, shrinking brick, ball.
  always_comb begin
    rgb_sel = 24'h000000;
    if (win_p1)          rgb_sel = text_p1 ? 24'h000000 : 24'h00C957;
    else if (lose_p1)    rgb_sel = text_p1 ? 24'h000000 : 24'h800000;
    else if (paddle_p1)  rgb_sel = 24'hB0E222;
    else if (alive_p1)   rgb_sel = edge_p1 ? 24'hABDD1D : 24'h5422E2;
    else if (shrink_p1)  rgb_sel = 24'h2A1171;
    else if (ball_p1)    rgb_sel = 24'h00FFFF;
  end

  logic [COLOR_W-1:0] red_p2, green_p2, blue_p2;
  logic               vld_p2;

  // Stage 2: register the colour.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      red_p2   <= '0;
      green_p2 <= '0;
      blue_p2  <= '0;
      vld_p2   <= 1'b0;
    end else begin
      red_p2   <= chan(rgb_sel[23:16]);
      green_p2 <= chan(rgb_sel[15:8]);
      blue_p2  <= chan(rgb_sel[7:0]);
      vld_p2   <= vld_p1;
    end
  end

  assign Red       = red_p2;
  assign Green     = green_p2;
  assign Blue      = blue_p2;
  assign rgb_valid = vld_p2;

endmodule

// File: tb/tb_brick_pixel_renderer.sv
// Directed bench for brick_pixel_renderer: a vector table for static scenes
// plus hand-written sequences for reset, shrink animation and FSM races.
module tb_brick_pixel_renderer;

  localparam int NB = 9;
  localparam int CW = 10;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          frame_tick;
  logic          pix_valid;
  logic [CW-1:0] DrawX, DrawY, BallX, BallY, Ball_size;
  logic [NB-1:0] brick_exists;
  logic [NB*CW-1:0] brick_x_vals, brick_y_vals;
  logic [CW-1:0] brick_width, brick_height;
  logic [CW-1:0] paddle_x, paddle_y, paddle_width, paddle_height;
  logic          did_win_game, did_lose_game, text_pix_on;
  logic [7:0]    Red, Green, Blue;
  logic          rgb_valid;

  int checks = 0;
  int errors = 0;

  brick_pixel_renderer dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .pix_valid(pix_valid),
    .DrawX(DrawX), .DrawY(DrawY), .BallX(BallX), .BallY(BallY), .Ball_size(Ball_size),
    .brick_exists(brick_exists), .brick_x_vals(brick_x_vals), .brick_y_vals(brick_y_vals),
    .brick_width(brick_width), .brick_height(brick_height),
    .paddle_x(paddle_x), .paddle_y(paddle_y), .paddle_width(paddle_width),
    .paddle_height(paddle_height), .did_win_game(did_win_game),
    .did_lose_game(did_lose_game), .text_pix_on(text_pix_on),
    .Red(Red), .Green(Green), .Blue(Blue), .rgb_valid(rgb_valid)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        pv;
    logic        win;
    logic        lose;
    logic        text;
    logic [23:0] rgb;
    logic        vld;
    logic [95:0] name;
  } vec_t;

  vec_t vecs [21];

  task automatic compare(input logic [23:0] exp_rgb, input logic exp_vld, input logic [95:0] name);
    logic [23:0] got;
    got = {Red, Green, Blue};
    checks++;
    if (got !== exp_rgb || rgb_valid !== exp_vld) begin
      errors++;
      $display("FAIL %s: got rgb=%h vld=%b, expected rgb=%h vld=%b", name, got, rgb_valid, exp_rgb, exp_vld);
    end
  endtask

  // Apply a pixel at the falling edge and sample two rising edges later.
  task automatic check_px(input logic [9:0] x, input logic [9:0] y, input logic pv,
                          input logic win, input logic lose, input logic text,
                          input logic [23:0] exp_rgb, input logic exp_vld, input logic [95:0] name);
    @(negedge Clk);
    DrawX = x; DrawY = y; pix_valid = pv;
    did_win_game = win; did_lose_game = lose; text_pix_on = text;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    compare(exp_rgb, exp_vld, name);
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge Clk); frame_tick = 1'b1;
      @(negedge Clk); frame_tick = 1'b0;
    end
  endtask

  initial begin
    Reset_n = 1'b0; frame_tick = 1'b0; pix_valid = 1'b1;
    DrawX = 10'd130; DrawY = 10'd60;
    BallX = 10'd320; BallY = 10'd240; Ball_size = 10'd4;
    brick_exists = '0; brick_x_vals = '0; brick_y_vals = '0;
    brick_x_vals[0*CW +: CW] = 10'd100;  brick_y_vals[0*CW +: CW] = 10'd50;
    brick_x_vals[1*CW +: CW] = 10'd500;  brick_y_vals[1*CW +: CW] = 10'd50;
    brick_x_vals[2*CW +: CW] = 10'd1000; brick_y_vals[2*CW +: CW] = 10'd900;
    brick_width = 10'd60; brick_height = 10'd20;
    paddle_x = 10'd300; paddle_y = 10'd400; paddle_width = 10'd80; paddle_height = 10'd10;
    did_win_game = 1'b0; did_lose_game = 1'b0; text_pix_on = 1'b0;

    vecs[0]  = '{10'd130,  10'd60,  1'b1, 1'b0, 1'b0, 1'b0, 24'h5422E2, 1'b1, "alive_mid"};
    vecs[1]  = '{10'd100,  10'd50,  1'b1, 1'b0, 1'b0, 1'b0, 24'hABDD1D, 1'b1, "edge_tl"};
    vecs[2]  = '{10'd159,  10'd69,  1'b1, 1'b0, 1'b0, 1'b0, 24'hABDD1D, 1'b1, "edge_br"};
    vecs[3]  = '{10'd160,  10'd60,  1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, "x_open"};
    vecs[4]  = '{10'd130,  10'd70,  1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, "y_open"};
    vecs[5]  = '{10'd130,  10'd50,  1'b1, 1'b0, 1'b0, 1'b0, 24'hABDD1D, 1'b1, "edge_top"};
    vecs[6]  = '{10'd530,  10'd60,  1'b1, 1'b0, 1'b0, 1'b0, 24'h5422E2, 1'b1, "brick1"};
    vecs[7]  = '{10'd1023, 10'd910, 1'b1, 1'b0, 1'b0, 1'b0, 24'h5422E2, 1'b1, "no_wrap"};
    vecs[8]  = '{10'd999,  10'd910, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, "left_out"};
    vecs[9]  = '{10'd324,  10'd240, 1'b1, 1'b0, 1'b0, 1'b0, 24'h00FFFF, 1'b1, "ball_rim"};
    vecs[10] = '{10'd323,  10'd243, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, "ball_out"};
    vecs[11] = '{10'd320,  10'd236, 1'b1, 1'b0, 1'b0, 1'b0, 24'h00FFFF, 1'b1, "ball_top"};
    vecs[12] = '{10'd310,  10'd405, 1'b1, 1'b0, 1'b0, 1'b0, 24'hB0E222, 1'b1, "paddle"};
    vecs[13] = '{10'd380,  10'd405, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, "pad_open"};
    vecs[14] = '{10'd130,  10'd60,  1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, "pv_off"};
    vecs[15] = '{10'd130,  10'd60,  1'b1, 1'b1, 1'b1, 1'b0, 24'h00C957, 1'b1, "win_lose"};
    vecs[16] = '{10'd130,  10'd60,  1'b1, 1'b1, 1'b1, 1'b1, 24'h000000, 1'b1, "win_text"};
    vecs[17] = '{10'd130,  10'd60,  1'b1, 1'b0, 1'b1, 1'b0, 24'h800000, 1'b1, "lose"};
    vecs[18] = '{10'd130,  10'd60,  1'b1, 1'b0, 1'b1, 1'b1, 24'h000000, 1'b1, "lose_text"};
    vecs[19] = '{10'd130,  10'd60,  1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, "win_pv0"};
    vecs[20] = '{10'd5,    10'd5,   1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, "background"};

    // Reset state
    #1;
    compare(24'h000000, 1'b0, "reset_out");
    @(negedge Clk); @(negedge Clk);
    brick_exists = 9'b000000111;
    Reset_n = 1'b1;
    @(negedge Clk); @(negedge Clk);

    // Static scenes
    for (int i = 0; i < 21; i++)
      check_px(vecs[i].x, vecs[i].y, vecs[i].pv, vecs[i].win, vecs[i].lose, vecs[i].text,
               vecs[i].rgb, vecs[i].vld, vecs[i].name);

    // Ball underneath the paddle
    @(negedge Clk); BallY = 10'd405;
    check_px(10'd320, 10'd405, 1'b1, 1'b0, 1'b0, 1'b0, 24'hB0E222, 1'b1, "ball_under_pad");
    @(negedge Clk); BallY = 10'd240;

    // Mid-frame reset clears the outputs at once; brick revives one clock after release
    check_px(10'd130, 10'd60, 1'b1, 1'b0, 1'b0, 1'b0, 24'h5422E2, 1'b1, "pre_reset");
    @(posedge Clk); #3;
    Reset_n = 1'b0;
    #1;
    compare(24'h000000, 1'b0, "async_reset");
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk); @(posedge Clk); #1;
    compare(24'h000000, 1'b1, "post_rst_gone");
    @(posedge Clk); #1;
    compare(24'h5422E2, 1'b1, "post_rst_alive");

    // Shrink animation of brick 0
    @(negedge Clk); brick_exists[0] = 1'b0;
    check_px(10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 1'b0, 24'h2A1171, 1'b1, "shr_noedge");
    tick(3);
    check_px(10'd103, 10'd53, 1'b1, 1'b0, 1'b0, 1'b0, 24'h2A1171, 1'b1, "shr_in3");
    check_px(10'd102, 10'd60, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, "shr_out3");
    tick(6);
    check_px(10'd109, 10'd59, 1'b1, 1'b0, 1'b0, 1'b0, 24'h2A1171, 1'b1, "shr_in9");
    tick(1);
    check_px(10'd130, 10'd60, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, "shr_gone");

    // Level reload, then drop coinciding with frame_tick
    @(negedge Clk); brick_exists[0] = 1'b1;
    check_px(10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 1'b0, 24'hABDD1D, 1'b1, "reload");
    @(negedge Clk); brick_exists[0] = 1'b0; frame_tick = 1'b1;
    @(negedge Clk); frame_tick = 1'b0;
    check_px(10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 1'b0, 24'h2A1171, 1'b1, "drop_tick");
    tick(1);
    check_px(10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, "inset1_out");
    check_px(10'd101, 10'd51, 1'b1, 1'b0, 1'b0, 1'b0, 24'h2A1171, 1'b1, "inset1_in");

    // Re-assert beats a simultaneous frame_tick and clears the inset
    @(negedge Clk); brick_exists[0] = 1'b1; frame_tick = 1'b1;
    @(negedge Clk); frame_tick = 1'b0;
    check_px(10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 1'b0, 24'hABDD1D, 1'b1, "reassert");
    @(negedge Clk); brick_exists[0] = 1'b0;
    check_px(10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 1'b0, 24'h2A1171, 1'b1, "inset_clr");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
